// File: rtl/muon_buffer_ctrl.sv
// Muon trigger capture sequencer for a ping-pong pair of BRAM event buffers.
// Writes a time-tag header plus a fixed ADC window per event and tracks buffer ownership.
module muon_buffer_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int WINDOW     = 16,
    parameter int TAG_WIDTH  = 32
) (
    input  logic                  CLK120,
    input  logic                  RESET,
    input  logic                  TRIG,
    input  logic                  ENABLE,
    input  logic [TAG_WIDTH-1:0]  TIME_TAG,
    input  logic [7:0]            EVT_PER_BUF,
    input  logic                  FLUSH,
    input  logic                  BUF_DONE,
    output logic                  MEM_WE,
    output logic                  MEM_BUF,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                  MEM_HDR,
    output logic [TAG_WIDTH-1:0]  MEM_TAG,
    output logic [1:0]            BUF_FULL,
    output logic                  BUF_RD,
    output logic [7:0]            BUF_NEVT0,
    output logic [7:0]            BUF_NEVT1,
    output logic [15:0]           DROP_CNT,
    output logic                  BUSY
);

    localparam int MAX_EVT = (2 ** ADDR_WIDTH) / (WINDOW + 1);
    localparam int MAX_CAP = (MAX_EVT > 255) ? 255 : MAX_EVT;
    localparam logic [7:0] MAX_EVT_L = 8'(MAX_CAP);
    localparam logic [ADDR_WIDTH-1:0] WIN_A = ADDR_WIDTH'(WINDOW);
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(WINDOW + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CLOSE
    } state_t;

    state_t                state_q, state_d;
    logic                  act_q, act_d;
    logic [7:0]            evt_cnt_q, evt_cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_buf_q, mem_buf_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_hdr_q, mem_hdr_d;
    logic [TAG_WIDTH-1:0]  mem_tag_q, mem_tag_d;
    logic [1:0]            buf_full_q, buf_full_d;
    logic                  buf_rd_q, buf_rd_d;
    logic [7:0]            nevt0_q, nevt0_d;
    logic [7:0]            nevt1_q, nevt1_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  busy_q, busy_d;

    logic [7:0] lim;
    logic [7:0] evt_next;
    logic       trig_on;
    logic       do_close;
    logic [7:0] close_n;

    // Effective events-per-buffer: zero means one, never beyond what physically fits
    always_comb begin
        lim = EVT_PER_BUF;
        if (lim == 8'd0) lim = 8'd1;
        if (lim > MAX_EVT_L) lim = MAX_EVT_L;
    end

    // Next-state logic for the capture FSM, buffer bookkeeping and drop counter
    always_comb begin
        state_d      = state_q;
        act_d        = act_q;
        evt_cnt_d    = evt_cnt_q;
        base_d       = base_q;
        flush_pend_d = flush_pend_q;
        mem_we_d     = 1'b0;
        mem_buf_d    = mem_buf_q;
        mem_addr_d   = mem_addr_q;
        mem_hdr_d    = 1'b0;
        mem_tag_d    = mem_tag_q;
        buf_full_d   = buf_full_q;
        buf_rd_d     = buf_rd_q;
        nevt0_d      = nevt0_q;
        nevt1_d      = nevt1_q;
        drop_cnt_d   = drop_cnt_q;
        trig_on      = TRIG & ENABLE;
        evt_next     = evt_cnt_q + 8'd1;
        do_close     = 1'b0;
        close_n      = evt_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (trig_on && !buf_full_q[act_q]) begin
                    state_d    = S_HDR;
                    mem_tag_d  = TIME_TAG;
                    mem_we_d   = 1'b1;
                    mem_hdr_d  = 1'b1;
                    mem_buf_d  = act_q;
                    mem_addr_d = base_q;
                    if (FLUSH) flush_pend_d = 1'b1;
                end else if (FLUSH && evt_cnt_q != 8'd0
                             && !buf_full_q[act_q]) begin
                    do_close = 1'b1;
                    close_n  = evt_cnt_q;
                end
            end
            S_HDR: begin
                state_d    = S_DATA;
                mem_we_d   = 1'b1;
                mem_addr_d = base_q + ADDR_WIDTH'(1);
                if (FLUSH) flush_pend_d = 1'b1;
            end
            S_DATA: begin
                if (mem_addr_q == base_q + WIN_A) begin
                    state_d = S_CLOSE;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                end
                if (FLUSH) flush_pend_d = 1'b1;
            end
            S_CLOSE: begin
                state_d      = S_IDLE;
                flush_pend_d = 1'b0;
                if (evt_next >= lim || flush_pend_q || FLUSH) begin
                    do_close = 1'b1;
                    close_n  = evt_next;
                end else begin
                    evt_cnt_d = evt_next;
                    base_d    = base_q + STRIDE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_close) begin
            buf_full_d[act_q] = 1'b1;
            if (act_q) nevt1_d = close_n;
            else       nevt0_d = close_n;
            act_d     = ~act_q;
            evt_cnt_d = 8'd0;
            base_d    = '0;
        end

        if (BUF_DONE && buf_full_q[buf_rd_q]) begin
            buf_full_d[buf_rd_q] = 1'b0;
            buf_rd_d             = ~buf_rd_q;
        end

        if (trig_on && (state_q != S_IDLE || buf_full_q[act_q])
            && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset discards any partial event
    always_ff @(posedge CLK120 or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            act_q        <= 1'b0;
            evt_cnt_q    <= 8'd0;
            base_q       <= '0;
            flush_pend_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_buf_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_hdr_q    <= 1'b0;
            mem_tag_q    <= '0;
            buf_full_q   <= 2'b00;
            buf_rd_q     <= 1'b0;
            nevt0_q      <= 8'd0;
            nevt1_q      <= 8'd0;
            drop_cnt_q   <= 16'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            evt_cnt_q    <= evt_cnt_d;
            base_q       <= base_d;
            flush_pend_q <= flush_pend_d;
            mem_we_q     <= mem_we_d;
            mem_buf_q    <= mem_buf_d;
            mem_addr_q   <= mem_addr_d;
            mem_hdr_q    <= mem_hdr_d;
            mem_tag_q    <= mem_tag_d;
            buf_full_q   <= buf_full_d;
            buf_rd_q     <= buf_rd_d;
            nevt0_q      <= nevt0_d;
            nevt1_q      <= nevt1_d;
            drop_cnt_q   <= drop_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign MEM_WE    = mem_we_q;
    assign MEM_BUF   = mem_buf_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_HDR   = mem_hdr_q;
    assign MEM_TAG   = mem_tag_q;
    assign BUF_FULL  = buf_full_q;
    assign BUF_RD    = buf_rd_q;
    assign BUF_NEVT0 = nevt0_q;
    assign BUF_NEVT1 = nevt1_q;
    assign DROP_CNT  = drop_cnt_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_muon_buffer_ctrl.sv
// Directed testbench for muon_buffer_ctrl.
// Each scenario task drives stimulus and checks hand-computed values.
module tb_muon_buffer_ctrl;

    localparam int AW  = 11;
    localparam int WIN = 16;
    localparam int TW  = 32;

    logic          CLK120 = 1'b0;
    logic          RESET;
    logic          TRIG;
    logic          ENABLE;
    logic [TW-1:0] TIME_TAG;
    logic [7:0]    EVT_PER_BUF;
    logic          FLUSH;
    logic          BUF_DONE;
    logic          MEM_WE;
    logic          MEM_BUF;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_HDR;
    logic [TW-1:0] MEM_TAG;
    logic [1:0]    BUF_FULL;
    logic          BUF_RD;
    logic [7:0]    BUF_NEVT0;
    logic [7:0]    BUF_NEVT1;
    logic [15:0]   DROP_CNT;
    logic          BUSY;

    int errors = 0;
    int checks = 0;

    muon_buffer_ctrl #(
        .ADDR_WIDTH(AW),
        .WINDOW    (WIN),
        .TAG_WIDTH (TW)
    ) dut (
        .CLK120     (CLK120),
        .RESET      (RESET),
        .TRIG       (TRIG),
        .ENABLE     (ENABLE),
        .TIME_TAG   (TIME_TAG),
        .EVT_PER_BUF(EVT_PER_BUF),
        .FLUSH      (FLUSH),
        .BUF_DONE   (BUF_DONE),
        .MEM_WE     (MEM_WE),
        .MEM_BUF    (MEM_BUF),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_HDR    (MEM_HDR),
        .MEM_TAG    (MEM_TAG),
        .BUF_FULL   (BUF_FULL),
        .BUF_RD     (BUF_RD),
        .BUF_NEVT0  (BUF_NEVT0),
        .BUF_NEVT1  (BUF_NEVT1),
        .DROP_CNT   (DROP_CNT),
        .BUSY       (BUSY)
    );

    always #5 CLK120 = ~CLK120;

    task automatic tick();
        @(posedge CLK120);
        #1;
    endtask

    // One full event; trig_at>0 holds TRIG high during cycle t+trig_at
    task automatic run_event(input logic [TW-1:0] tag, input logic eb,
                             input logic [AW-1:0] base, input int trig_at);
        logic [AW+2:0] got;
        logic [AW+2:0] exp;
        TIME_TAG = tag;
        TRIG = 1'b1;
        tick();
        for (int k = 1; k <= WIN + 2; k++) begin
            TRIG = (k == trig_at);
            if (k == 1) begin
                TIME_TAG = ~tag;
                checks++;
                if (MEM_TAG !== tag) begin
                    errors++;
                    $display("FAIL hdr_tag got=%h exp=%h", MEM_TAG, tag);
                end
                checks++;
                if (BUSY !== 1'b1) begin
                    errors++;
                    $display("FAIL hdr_busy got=%b exp=1", BUSY);
                end
            end
            got = {MEM_WE, MEM_HDR, MEM_BUF, MEM_ADDR};
            if (k == 1)
                exp = {1'b1, 1'b1, eb, base};
            else if (k <= WIN + 1)
                exp = {1'b1, 1'b0, eb, base + AW'(k - 1)};
            else
                exp = {1'b0, 1'b0, got[AW:0]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL evt_cycle%0d we/hdr/buf/addr got=%h exp=%h",
                         k, got, exp);
            end
            tick();
        end
        TRIG = 1'b0;
        checks++;
        if ({BUSY, MEM_WE} !== 2'b00) begin
            errors++;
            $display("FAIL evt_idle busy/we got=%b exp=00", {BUSY, MEM_WE});
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        TRIG = 1'b0;
        ENABLE = 1'b0;
        TIME_TAG = 32'h0;
        EVT_PER_BUF = 8'd2;
        FLUSH = 1'b0;
        BUF_DONE = 1'b0;
        tick();
        tick();
        checks++;
        if ({MEM_WE, MEM_BUF, MEM_ADDR, MEM_HDR, MEM_TAG, BUSY} !== '0) begin
            errors++;
            $display("FAIL reset_mem got=%b exp=0",
                     {MEM_WE, MEM_BUF, MEM_ADDR, MEM_HDR, MEM_TAG, BUSY});
        end
        checks++;
        if ({BUF_FULL, BUF_RD, BUF_NEVT0, BUF_NEVT1, DROP_CNT} !== '0) begin
            errors++;
            $display("FAIL reset_buf got=%h exp=0",
                     {BUF_FULL, BUF_RD, BUF_NEVT0, BUF_NEVT1, DROP_CNT});
        end
        RESET = 1'b0;
        tick();
        BUF_DONE = 1'b1;
        tick();
        BUF_DONE = 1'b0;
        checks++;
        if ({BUF_FULL, BUF_RD} !== 3'b000) begin
            errors++;
            $display("FAIL done_empty got=%b exp=000", {BUF_FULL, BUF_RD});
        end
    endtask

    task automatic test_single_event();
        ENABLE = 1'b1;
        run_event(32'h1234, 1'b0, 11'd0, 0);
        checks++;
        if (BUF_FULL !== 2'b00) begin
            errors++;
            $display("FAIL single_full got=%b exp=00", BUF_FULL);
        end
    endtask

    task automatic test_two_events();
        run_event(32'h2222, 1'b0, 11'd17, 0);
        checks++;
        if (BUF_FULL !== 2'b01) begin
            errors++;
            $display("FAIL two_full got=%b exp=01", BUF_FULL);
        end
        checks++;
        if (BUF_NEVT0 !== 8'd2) begin
            errors++;
            $display("FAIL two_nevt0 got=%0d exp=2", BUF_NEVT0);
        end
        run_event(32'h3333, 1'b1, 11'd0, 0);
    endtask

    task automatic test_drop_full();
        int we_seen = 0;
        run_event(32'h4444, 1'b1, 11'd17, 0);
        checks++;
        if ({BUF_FULL, BUF_NEVT1} !== {2'b11, 8'd2}) begin
            errors++;
            $display("FAIL fill_both full/nevt1 got=%h exp=302",
                     {BUF_FULL, BUF_NEVT1});
        end
        ENABLE = 1'b0;
        TRIG = 1'b1;
        tick();
        TRIG = 1'b0;
        ENABLE = 1'b1;
        checks++;
        if (DROP_CNT !== 16'd0) begin
            errors++;
            $display("FAIL trig_disabled drop got=%0d exp=0", DROP_CNT);
        end
        for (int i = 0; i < 3; i++) begin
            TRIG = 1'b1;
            tick();
            if (MEM_WE) we_seen++;
            TRIG = 1'b0;
            tick();
            if (MEM_WE) we_seen++;
        end
        checks++;
        if (DROP_CNT !== 16'd3 || we_seen != 0) begin
            errors++;
            $display("FAIL drop3 drop=%0d we=%0d exp drop=3 we=0",
                     DROP_CNT, we_seen);
        end
        BUF_DONE = 1'b1;
        tick();
        BUF_DONE = 1'b0;
        checks++;
        if ({BUF_FULL, BUF_RD} !== 3'b101) begin
            errors++;
            $display("FAIL done1 full/rd got=%b exp=101", {BUF_FULL, BUF_RD});
        end
        run_event(32'h5555, 1'b0, 11'd0, 0);
    endtask

    task automatic test_dead_time_drop();
        int we_seen = 0;
        run_event(32'h6666, 1'b0, 11'd17, 5);
        checks++;
        if (DROP_CNT !== 16'd4) begin
            errors++;
            $display("FAIL dead_drop got=%0d exp=4", DROP_CNT);
        end
        checks++;
        if ({BUF_FULL, BUF_NEVT0} !== {2'b11, 8'd2}) begin
            errors++;
            $display("FAIL dead_full full/nevt0 got=%h exp=302",
                     {BUF_FULL, BUF_NEVT0});
        end
        TRIG = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            tick();
            if (MEM_WE) we_seen++;
        end
        TRIG = 1'b0;
        tick();
        checks++;
        if (DROP_CNT !== 16'hFFFF || we_seen != 0) begin
            errors++;
            $display("FAIL drop_sat drop=%h we=%0d exp drop=ffff we=0",
                     DROP_CNT, we_seen);
        end
    endtask

    task automatic test_flush();
        BUF_DONE = 1'b1;
        tick();
        checks++;
        if ({BUF_FULL, BUF_RD} !== 3'b010) begin
            errors++;
            $display("FAIL done2 full/rd got=%b exp=010", {BUF_FULL, BUF_RD});
        end
        tick();
        BUF_DONE = 1'b0;
        checks++;
        if ({BUF_FULL, BUF_RD} !== 3'b001) begin
            errors++;
            $display("FAIL done3 full/rd got=%b exp=001", {BUF_FULL, BUF_RD});
        end
        EVT_PER_BUF = 8'd10;
        run_event(32'h7777, 1'b1, 11'd0, 0);
        checks++;
        if (BUF_FULL !== 2'b00) begin
            errors++;
            $display("FAIL pre_flush full got=%b exp=00", BUF_FULL);
        end
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        checks++;
        if ({BUF_FULL, BUF_NEVT1} !== {2'b10, 8'd1}) begin
            errors++;
            $display("FAIL flush full/nevt1 got=%h exp=201",
                     {BUF_FULL, BUF_NEVT1});
        end
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        tick();
        checks++;
        if ({BUF_FULL, BUF_NEVT0} !== {2'b10, 8'd2}) begin
            errors++;
            $display("FAIL flush_empty full/nevt0 got=%h exp=202",
                     {BUF_FULL, BUF_NEVT0});
        end
        EVT_PER_BUF = 8'd0;
        run_event(32'h8888, 1'b0, 11'd0, 0);
        checks++;
        if ({BUF_FULL, BUF_NEVT0} !== {2'b11, 8'd1}) begin
            errors++;
            $display("FAIL evt0_as_1 full/nevt0 got=%h exp=301",
                     {BUF_FULL, BUF_NEVT0});
        end
    endtask

    task automatic test_reset_mid_capture();
        BUF_DONE = 1'b1;
        tick();
        BUF_DONE = 1'b0;
        checks++;
        if ({BUF_FULL, BUF_RD} !== 3'b010) begin
            errors++;
            $display("FAIL done4 full/rd got=%b exp=010", {BUF_FULL, BUF_RD});
        end
        TIME_TAG = 32'h9999;
        TRIG = 1'b1;
        tick();
        TRIG = 1'b0;
        checks++;
        if ({MEM_WE, MEM_HDR, MEM_BUF} !== 3'b111) begin
            errors++;
            $display("FAIL rst_hdr we/hdr/buf got=%b exp=111",
                     {MEM_WE, MEM_HDR, MEM_BUF});
        end
        for (int i = 0; i < 5; i++) tick();
        RESET = 1'b1;
        #1;
        checks++;
        if ({MEM_WE, MEM_BUF, MEM_ADDR, MEM_HDR, MEM_TAG, BUSY,
             BUF_FULL, BUF_RD, BUF_NEVT0, BUF_NEVT1, DROP_CNT} !== '0) begin
            errors++;
            $display("FAIL async_reset outputs not all zero");
        end
        RESET = 1'b0;
        tick();
        run_event(32'hAAAA, 1'b0, 11'd0, 0);
        checks++;
        if ({BUF_FULL, BUF_NEVT0, DROP_CNT} !== {2'b01, 8'd1, 16'd0}) begin
            errors++;
            $display("FAIL post_reset full/nevt0/drop got=%h exp=1010000",
                     {BUF_FULL, BUF_NEVT0, DROP_CNT});
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_two_events();
        test_drop_full();
        test_dead_time_drop();
        test_flush();
        test_reset_mid_capture();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
